// File: rtl/selector_pkg.sv
// Shared mode and state encodings for the one-hot selector.
package selector_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_PULSE = 2'd1,
      MODE_SWEEP = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_PULSE = 2'd2,
      S_SWEEP = 2'd3
   } state_e;

endpackage

// File: rtl/selector_onehot_dec.sv
// Combinational address-to-one-hot decoder; addresses at or beyond OUT_N decode to zero.
module selector_onehot_dec #(
   parameter int ADDR_W = 8,
   parameter int OUT_N  = 1 << ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output logic [OUT_N-1:0]  onehot
);

   // each line matches only its own index, so out-of-range addresses select nothing
   always_comb begin
      onehot = '0;
      for (int i = 0; i < OUT_N; i++) begin
         if (en && (addr == ADDR_W'(i))) begin
            onehot[i] = 1'b1;
         end else begin
            onehot[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/selector_sweep.sv
// Registered one-hot selector with hold, timed pulse and timed wrap-around sweep modes.
module selector_sweep
   import selector_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int OUT_N   = 1 << ADDR_W,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [1:0]         load_mode,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [ADDR_W-1:0]  sweep_end,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               abort,
   output logic [OUT_N-1:0]   decoded,
   output logic [ADDR_W-1:0]  active_addr,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [ADDR_W:0]   OUT_N_W   = (ADDR_W+1)'(OUT_N);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_N - 1);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < OUT_N_W);
   endfunction

   // wraps at OUT_N rather than at the natural 2^ADDR_W boundary
   function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction

   state_e               state_r, state_s;
   mode_e                mode_s;
   logic [ADDR_W-1:0]    addr_s, end_r, end_s;
   logic [DWELL_W-1:0]   reload_r, reload_s, cnt_r, cnt_s, dw_eff_s;
   logic                 accept_s, done_s, err_s, en_s;
   logic [OUT_N-1:0]     dec_s;

   assign load_ready = rst_n && ((state_r == S_IDLE) || (state_r == S_HOLD)) && !abort;
   assign accept_s   = load_valid && load_ready;
   assign mode_s     = mode_e'(load_mode);
   assign dw_eff_s   = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign en_s       = (state_s != S_IDLE);

   // next-state, address and dwell-counter computation
   always_comb begin
      state_s  = state_r;
      addr_s   = active_addr;
      end_s    = end_r;
      reload_s = reload_r;
      cnt_s    = cnt_r;
      done_s   = 1'b0;
      err_s    = 1'b0;
      if (abort) begin
         state_s = S_IDLE;
      end else if (accept_s) begin
         if ((mode_s == MODE_RSVD) || !in_range(load_addr) ||
             ((mode_s == MODE_SWEEP) && !in_range(sweep_end))) begin
            state_s = S_IDLE;
            err_s   = 1'b1;
         end else begin
            addr_s   = load_addr;
            end_s    = sweep_end;
            reload_s = dw_eff_s;
            cnt_s    = dw_eff_s - DWELL_W'(1);
            case (mode_s)
               MODE_HOLD:  state_s = S_HOLD;
               MODE_PULSE: state_s = S_PULSE;
               MODE_SWEEP: state_s = S_SWEEP;
               default:    state_s = S_IDLE;
            endcase
         end
      end else begin
         case (state_r)
            S_PULSE: begin
               if (cnt_r == '0) begin
                  state_s = S_IDLE;
                  done_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r - DWELL_W'(1);
               end
            end
            S_SWEEP: begin
               if (cnt_r != '0) begin
                  cnt_s = cnt_r - DWELL_W'(1);
               end else if (active_addr == end_r) begin
                  state_s = S_IDLE;
                  done_s  = 1'b1;
               end else begin
                  addr_s = step_addr(active_addr);
                  cnt_s  = reload_r - DWELL_W'(1);
               end
            end
            default: state_s = state_r;
         endcase
      end
   end

   // decoding the next address keeps the select register itself one-hot on every step
   selector_onehot_dec #(
      .ADDR_W (ADDR_W),
      .OUT_N  (OUT_N)
   ) u_dec (
      .addr   (addr_s),
      .en     (en_s),
      .onehot (dec_s)
   );

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         end_r       <= '0;
         reload_r    <= DWELL_W'(1);
         cnt_r       <= '0;
         decoded     <= '0;
         active_addr <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_r     <= state_s;
         end_r       <= end_s;
         reload_r    <= reload_s;
         cnt_r       <= cnt_s;
         decoded     <= dec_s;
         active_addr <= en_s ? addr_s : '0;
         busy        <= (state_s == S_PULSE) || (state_s == S_SWEEP);
         done        <= done_s;
         err         <= err_s;
      end
   end

endmodule

// File: tb/tb_selector_sweep.sv
// Bench for selector_sweep: two instances (OUT_N=256 and OUT_N=200) against a schedule-based model.
module tb_selector_sweep;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_valid = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    load_mode = 2'd0;
   logic [7:0]    load_addr = 8'd0;
   logic [7:0]    sweep_end = 8'd0;
   logic [15:0]   dwell = 16'd0;

   logic          ready0, ready1, busy0, busy1, done0, done1, err0, err1;
   logic [255:0]  dec0;
   logic [199:0]  dec1;
   logic [7:0]    aa0, aa1;

   always #5 clk = ~clk;

   selector_sweep dut0 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready0),
      .load_mode(load_mode), .load_addr(load_addr), .sweep_end(sweep_end),
      .dwell(dwell), .abort(abort), .decoded(dec0), .active_addr(aa0),
      .busy(busy0), .done(done0), .err(err0));

   selector_sweep #(.OUT_N(200)) dut1 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready1),
      .load_mode(load_mode), .load_addr(load_addr), .sweep_end(sweep_end),
      .dwell(dwell), .abort(abort), .decoded(dec1), .active_addr(aa1),
      .busy(busy1), .done(done1), .err(err1));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each timed load becomes a per-cycle list of addresses to show; HOLD is a sticky address.
   int nsel[2] = '{256, 200};
   int sched[2][1024];
   int slen[2], spos[2], cur[2];
   bit hold[2], done_e[2], err_e[2];

   task automatic model_reset(input int k);
      cur[k] = -1; hold[k] = 1'b0; slen[k] = 0; spos[k] = 0;
      done_e[k] = 1'b0; err_e[k] = 1'b0;
   endtask

   task automatic model_step(input int k);
      bit bz;
      int d, a, guard;
      bz = (cur[k] >= 0) && !hold[k];
      d = (dwell == 16'd0) ? 1 : int'(dwell);
      done_e[k] = 1'b0;
      err_e[k] = 1'b0;
      if (abort) begin
         model_reset(k);
      end else if (load_valid && !bz) begin
         if (load_mode == 2'd3 || int'(load_addr) >= nsel[k] ||
             (load_mode == 2'd2 && int'(sweep_end) >= nsel[k])) begin
            model_reset(k);
            err_e[k] = 1'b1;
         end else if (load_mode == 2'd0) begin
            cur[k] = int'(load_addr); hold[k] = 1'b1; slen[k] = 0;
         end else begin
            hold[k] = 1'b0; slen[k] = 0; a = int'(load_addr); guard = 0;
            forever begin
               for (int i = 0; i < d; i++) begin sched[k][slen[k]] = a; slen[k]++; end
               guard++;
               if (load_mode == 2'd1 || a == int'(sweep_end) || guard > 256) break;
               a = (a + 1) % nsel[k];
            end
            cur[k] = sched[k][0]; spos[k] = 1;
         end
      end else if (bz) begin
         if (spos[k] < slen[k]) begin cur[k] = sched[k][spos[k]]; spos[k]++; end
         else begin cur[k] = -1; done_e[k] = 1'b1; end
      end
   endtask

   task automatic compare(input int k);
      logic [255:0] dv, ev;
      logic         bv, dn, er, rd;
      logic [7:0]   av;
      dv = (k == 0) ? dec0 : {56'd0, dec1};
      bv = (k == 0) ? busy0 : busy1;
      dn = (k == 0) ? done0 : done1;
      er = (k == 0) ? err0 : err1;
      rd = (k == 0) ? ready0 : ready1;
      av = (k == 0) ? aa0 : aa1;
      ev = (cur[k] >= 0) ? (256'd1 << cur[k]) : 256'd0;
      check($sformatf("decoded%0d", k), dv, ev);
      check($sformatf("busy%0d", k), bv, (cur[k] >= 0) && !hold[k]);
      check($sformatf("done%0d", k), dn, done_e[k]);
      check($sformatf("err%0d", k), er, err_e[k]);
      check($sformatf("load_ready%0d", k), rd, rst_n && !((cur[k] >= 0) && !hold[k]) && !abort);
      check($sformatf("popcount%0d", k), ($countones(dv) <= 1), 1'b1);
      if (cur[k] >= 0) check($sformatf("active_addr%0d", k), av, cur[k]);
   endtask

   // per-cycle comparison away from the active edge, then advance the model with the inputs the DUT will sample
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) model_reset(k);
         compare(k);
         if (rst_n) model_step(k);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] a, input logic [7:0] e,
                        input logic [15:0] d, input logic ab);
      load_valid = v; load_mode = m; load_addr = a; sweep_end = e; dwell = d; abort = ab;
   endtask

   task automatic measure_pulse(output int hi, output logic dn);
      bit seen;
      hi = 0; dn = 1'b0; seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (dec0[7]) hi++;
         else if (!seen) begin seen = 1'b1; dn = done0; end
         tick();
      end
   endtask

   int    hi, stable, n, bad;
   logic  dn;
   int    seq[$];
   int    exp4[12] = '{253, 253, 254, 254, 255, 255, 0, 0, 1, 1, 2, 2};
   int    exp4b[4] = '{198, 199, 0, 1};

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("reset_decoded", dec0, 256'd0);
      check("reset_ready", ready0, 1'b1);
      check("reset_busy", busy0, 1'b0);

      drive(1'b1, 2'd0, 8'd1, 8'd0, 16'd0, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("hold1_decoded", dec0, 256'h2);
      check("hold1_addr", aa0, 8'd1);
      stable = 0;
      for (int i = 0; i < 1000; i++) begin
         if (dec0 == 256'h2 && aa0 == 8'd1) stable++;
         tick();
      end
      check("hold1_stable", stable, 1000);

      drive(1'b1, 2'd0, 8'd5, 8'd0, 16'd0, 1'b0); tick();
      check("hold5", dec0, 256'd1 << 5);
      drive(1'b1, 2'd0, 8'd200, 8'd0, 16'd0, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("hold200", dec0, 256'd1 << 200);
      check("hold200_reject_n200", err1, 1'b1);

      drive(1'b1, 2'd1, 8'd7, 8'd0, 16'd3, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("pulse_ready_low", ready0, 1'b0);
      measure_pulse(hi, dn);
      check("pulse3_len", hi, 3);
      check("pulse3_done", dn, 1'b1);
      drive(1'b1, 2'd1, 8'd7, 8'd0, 16'd0, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      measure_pulse(hi, dn);
      check("pulse0_len", hi, 1);

      drive(1'b1, 2'd2, 8'd253, 8'd2, 16'd2, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("sweep253_reject_n200", err1, 1'b1);
      seq.delete(); dn = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (dec0 != 256'd0) seq.push_back(int'(aa0));
         else if (seq.size() == 12) dn = dn | done0;
         tick();
      end
      check("sweep_len", seq.size(), 12);
      bad = 0;
      for (int i = 0; i < 12 && i < seq.size(); i++) if (seq[i] != exp4[i]) bad++;
      check("sweep_order", bad, 0);
      check("sweep_done", dn, 1'b1);

      drive(1'b1, 2'd2, 8'd198, 8'd1, 16'd1, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      seq.delete();
      for (int i = 0; i < 80; i++) begin
         if (dec1 != 200'd0) seq.push_back(int'(aa1));
         tick();
      end
      check("wrap200_len", seq.size(), 4);
      bad = 0;
      for (int i = 0; i < 4 && i < seq.size(); i++) if (seq[i] != exp4b[i]) bad++;
      check("wrap200_order", bad, 0);
      n = 0;
      while ((busy0 || busy1) && n < 200) begin tick(); n++; end
      check("idle_bound", busy0 | busy1, 1'b0);

      drive(1'b1, 2'd0, 8'd250, 8'd0, 16'd0, 1'b0); tick();
      check("rej_addr_err", err1, 1'b1);
      check("rej_addr_dec", dec1, 200'd0);
      check("hold250_n256", dec0, 256'd1 << 250);
      drive(1'b1, 2'd3, 8'd5, 8'd0, 16'd0, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("rej_mode_err", err0, 1'b1);
      check("rej_mode_dec", dec0, 256'd0);
      tick();

      drive(1'b1, 2'd2, 8'd10, 8'd20, 16'd2, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      repeat (3) tick();
      check("abort_pre_addr", aa0, 8'd11);
      drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b1); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("abort_dec", dec0, 256'd0);
      check("abort_done", done0, 1'b0);
      check("abort_busy", busy0, 1'b0);
      drive(1'b1, 2'd0, 8'd3, 8'd0, 16'd0, 1'b1); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      check("abort_load_ignored", dec0, 256'd0);

      drive(1'b1, 2'd2, 8'd0, 8'd100, 16'd3, 1'b0); tick(); drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("rst_async_dec", dec0, 256'd0);
      check("rst_async_busy", busy0, 1'b0);
      check("rst_async_addr", aa0, 8'd0);
      check("rst_ready", ready0, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 16'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 63) != 0);
         tick();
      end
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b1); tick();
      drive(1'b0, 2'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
